simplebus_mem_arbiter: RTL and testbench

//  Shares one SimpleBus memory port between IFU (read-only) and LSU (read/write) requesters of the core.

---
 rtl/simplebus_mem_arbiter_if.sv | 47 ++++
 rtl/simplebus_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_simplebus_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simplebus_mem_arbiter_if.sv
// SimpleBus signal bundle around the memory arbiter: IFU and LSU requester ports plus the shared memory port.
// The arbiter connects through the slave modport; the core/memory environment connects through master.
interface simplebus_mem_arbiter_if;
  logic        ifu_reqValid;
  logic [31:0] ifu_addr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  logic        lsu_reqValid;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  ifu_reqValid, ifu_addr,
    input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_respValid, mem_rdata,
    output ifu_respValid, ifu_rdata, ifu_err,
    output lsu_respValid, lsu_rdata, lsu_err,
    output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    output busy
  );

  modport master (
    output ifu_reqValid, ifu_addr,
    output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_respValid, mem_rdata,
    input  ifu_respValid, ifu_rdata, ifu_err,
    input  lsu_respValid, lsu_rdata, lsu_err,
    input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
    input  busy
  );
endinterface

// File: rtl/simplebus_mem_arbiter.sv
// Shares one SimpleBus memory port between IFU (read-only) and LSU (read/write), one latched
// transaction at a time, with a watchdog that ends a transaction the memory never answers.
module simplebus_mem_arbiter #(
  parameter bit RR_EN   = 1'b0,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  simplebus_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_IFU = 2'd1,
    S_BUSY_LSU = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_addr;
  logic [1:0]      r_size;
  logic            r_wen;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wmask;
  logic [TO_W-1:0] r_wd;
  logic            r_ifu_turn;
  logic            w_grant_ifu;
  logic            w_grant_lsu;
  logic            w_busy;
  logic            w_timeout;
  logic            w_done;

  // Winner selection in IDLE; r_ifu_turn names who takes the next tie (IFU out of reset)
  always_comb begin
    w_grant_ifu = 1'b0;
    w_grant_lsu = 1'b0;
    if (r_state == S_IDLE) begin
      if (bus.ifu_reqValid && bus.lsu_reqValid) begin
        if (RR_EN && r_ifu_turn) begin
          w_grant_ifu = 1'b1;
        end else begin
          w_grant_lsu = 1'b1;
        end
      end else begin
        w_grant_ifu = bus.ifu_reqValid;
        w_grant_lsu = bus.lsu_reqValid;
      end
    end else begin
      w_grant_ifu = 1'b0;
      w_grant_lsu = 1'b0;
    end
  end

  assign w_busy    = (r_state != S_IDLE);
  // A real response in the last watchdog cycle takes precedence over the timeout
  assign w_timeout = (TIMEOUT != 0) && w_busy && (r_wd == TO_LAST) && !bus.mem_respValid;
  assign w_done    = w_busy && (bus.mem_respValid || w_timeout);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_lsu) begin
          w_state_nxt = S_BUSY_LSU;
        end else if (w_grant_ifu) begin
          w_state_nxt = S_BUSY_IFU;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY_IFU, S_BUSY_LSU: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latched request fields, watchdog and tie-break history
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr     <= 32'h0;
      r_size     <= 2'd0;
      r_wen      <= 1'b0;
      r_wdata    <= 32'h0;
      r_wmask    <= 4'h0;
      r_wd       <= '0;
      r_ifu_turn <= 1'b1;
    end else begin
      if (w_grant_lsu) begin
        r_addr     <= bus.lsu_addr;
        r_size     <= bus.lsu_size;
        r_wen      <= bus.lsu_wen;
        r_wdata    <= bus.lsu_wdata;
        r_wmask    <= bus.lsu_wmask;
        r_ifu_turn <= 1'b1;
      end else if (w_grant_ifu) begin
        r_addr     <= bus.ifu_addr;
        r_size     <= 2'd2;
        r_wen      <= 1'b0;
        r_wdata    <= 32'h0;
        r_wmask    <= 4'h0;
        r_ifu_turn <= 1'b0;
      end
      if (!w_busy || w_done) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + TO_W'(1);
      end
    end
  end

  // Output decode; everything is held at zero while reset is asserted
  always_comb begin
    bus.ifu_respValid = 1'b0;
    bus.ifu_rdata     = 32'h0;
    bus.ifu_err       = 1'b0;
    bus.lsu_respValid = 1'b0;
    bus.lsu_rdata     = 32'h0;
    bus.lsu_err       = 1'b0;
    bus.mem_reqValid  = 1'b0;
    bus.mem_addr      = 32'h0;
    bus.mem_size      = 2'd0;
    bus.mem_wen       = 1'b0;
    bus.mem_wdata     = 32'h0;
    bus.mem_wmask     = 4'h0;
    bus.busy          = 1'b0;
    if (reset && w_busy) begin
      bus.mem_reqValid = 1'b1;
      bus.mem_addr     = r_addr;
      bus.mem_size     = r_size;
      bus.mem_wen      = r_wen;
      bus.mem_wdata    = r_wdata;
      bus.mem_wmask    = r_wmask;
      bus.busy         = 1'b1;
      case (r_state)
        S_BUSY_IFU: begin
          bus.ifu_respValid = w_done;
          bus.ifu_err       = w_timeout;
          bus.ifu_rdata     = bus.mem_respValid ? bus.mem_rdata : 32'h0;
        end
        S_BUSY_LSU: begin
          bus.lsu_respValid = w_done;
          bus.lsu_err       = w_timeout;
          bus.lsu_rdata     = bus.mem_respValid ? bus.mem_rdata : 32'h0;
        end
        default: begin
          bus.ifu_respValid = 1'b0;
          bus.lsu_respValid = 1'b0;
        end
      endcase
    end else begin
      bus.busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_simplebus_mem_arbiter.sv
// Bench for simplebus_mem_arbiter: a fixed-priority and a round-robin instance (both TIMEOUT=4),
// directed scenarios plus randomized masters/memory checked against a transaction-level model.
module tb_simplebus_mem_arbiter;
  localparam int TMO = 4;

  logic        clock;
  logic        reset;
  logic        sel;
  logic        d_ifu_req;
  logic [31:0] d_ifu_addr;
  logic        d_lsu_req;
  logic [31:0] d_lsu_addr;
  logic [1:0]  d_lsu_size;
  logic        d_lsu_wen;
  logic [31:0] d_lsu_wdata;
  logic [3:0]  d_lsu_wmask;
  logic        d_mem_resp;
  logic [31:0] d_mem_rdata;
  int          n_checks;
  int          n_pass;

  simplebus_mem_arbiter_if bf ();
  simplebus_mem_arbiter_if br ();

  simplebus_mem_arbiter #(.RR_EN(1'b0), .TIMEOUT(TMO), .TO_W(8)) u_fp (.clock(clock), .reset(reset), .bus(bf));
  simplebus_mem_arbiter #(.RR_EN(1'b1), .TIMEOUT(TMO), .TO_W(8)) u_rr (.clock(clock), .reset(reset), .bus(br));

  // Only the selected instance sees requests and memory responses
  assign bf.ifu_reqValid  = d_ifu_req & ~sel;
  assign br.ifu_reqValid  = d_ifu_req & sel;
  assign bf.lsu_reqValid  = d_lsu_req & ~sel;
  assign br.lsu_reqValid  = d_lsu_req & sel;
  assign bf.mem_respValid = d_mem_resp & ~sel;
  assign br.mem_respValid = d_mem_resp & sel;
  assign bf.ifu_addr  = d_ifu_addr;   assign br.ifu_addr  = d_ifu_addr;
  assign bf.lsu_addr  = d_lsu_addr;   assign br.lsu_addr  = d_lsu_addr;
  assign bf.lsu_size  = d_lsu_size;   assign br.lsu_size  = d_lsu_size;
  assign bf.lsu_wen   = d_lsu_wen;    assign br.lsu_wen   = d_lsu_wen;
  assign bf.lsu_wdata = d_lsu_wdata;  assign br.lsu_wdata = d_lsu_wdata;
  assign bf.lsu_wmask = d_lsu_wmask;  assign br.lsu_wmask = d_lsu_wmask;
  assign bf.mem_rdata = d_mem_rdata;  assign br.mem_rdata = d_mem_rdata;

  wire [67:0] w_resp_fp = {bf.ifu_respValid, bf.ifu_err, bf.ifu_rdata, bf.lsu_respValid, bf.lsu_err, bf.lsu_rdata};
  wire [67:0] w_resp_rr = {br.ifu_respValid, br.ifu_err, br.ifu_rdata, br.lsu_respValid, br.lsu_err, br.lsu_rdata};
  wire [72:0] w_mem_fp  = {bf.busy, bf.mem_reqValid, bf.mem_addr, bf.mem_size, bf.mem_wen, bf.mem_wdata, bf.mem_wmask};
  wire [72:0] w_mem_rr  = {br.busy, br.mem_reqValid, br.mem_addr, br.mem_size, br.mem_wen, br.mem_wdata, br.mem_wmask};
  wire [67:0] obs_resp  = sel ? w_resp_rr : w_resp_fp;
  wire [72:0] obs_mem   = sel ? w_mem_rr : w_mem_fp;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    d_ifu_req = 1'b0; d_ifu_addr = 32'h0; d_lsu_req = 1'b0; d_lsu_addr = 32'h0;
    d_lsu_size = 2'd0; d_lsu_wen = 1'b0; d_lsu_wdata = 32'h0; d_lsu_wmask = 4'h0;
    d_mem_resp = 1'b0; d_mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [281:0] all_out;
    sel = 1'b0;
    idle_inputs();
    reset = 1'b0;
    d_ifu_req = 1'b1; d_lsu_req = 1'b1; d_mem_resp = 1'b1; d_mem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    @(negedge clock);
    all_out = {w_resp_fp, w_mem_fp, w_resp_rr, w_mem_rr};
    n_checks++;
    if (all_out !== 282'h0) $display("FAIL reset_held: got %h required 0", all_out);
    else n_pass++;
    tick();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    all_out = {w_resp_fp, w_mem_fp, w_resp_rr, w_mem_rr};
    n_checks++;
    if (all_out !== 282'h0) $display("FAIL reset_released: got %h required 0", all_out);
    else n_pass++;
    tick();
  endtask

  task automatic test_ifu_single();
    sel = 1'b0;
    do_reset();
    d_ifu_req = 1'b1; d_ifu_addr = 32'h8000_0000;
    @(negedge clock);
    n_checks++;
    if (obs_mem !== 73'h0) $display("FAIL ifu1_t0_mem: got %h required 0", obs_mem);
    else n_pass++;
    tick();
    @(negedge clock);
    n_checks++;
    if (obs_mem !== {1'b1, 1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'h0, 4'h0} || obs_resp !== 68'h0)
      $display("FAIL ifu1_t1: got mem %h resp %h", obs_mem, obs_resp);
    else n_pass++;
    tick();
    d_mem_resp = 1'b1; d_mem_rdata = 32'h0010_0073;
    @(negedge clock);
    n_checks++;
    if (obs_resp !== {1'b1, 1'b0, 32'h0010_0073, 1'b0, 1'b0, 32'h0} || obs_mem[71] !== 1'b1)
      $display("FAIL ifu1_t2_resp: got resp %h mem %h required ifu resp 00100073", obs_resp, obs_mem);
    else n_pass++;
    tick();
    idle_inputs();
    @(negedge clock);
    n_checks++;
    if (obs_mem[72] !== 1'b0 || obs_resp !== 68'h0) $display("FAIL ifu1_t3_idle: got busy %b resp %h", obs_mem[72], obs_resp);
    else n_pass++;
    tick();
  endtask

  task automatic test_fixed_priority();
    sel = 1'b0;
    do_reset();
    d_ifu_req = 1'b1; d_ifu_addr = 32'h8000_0040;
    d_lsu_req = 1'b1; d_lsu_addr = 32'h8000_1000; d_lsu_size = 2'd2; d_lsu_wen = 1'b1;
    d_lsu_wdata = 32'hDEAD_BEEF; d_lsu_wmask = 4'hF;
    tick();
    d_mem_resp = 1'b1; d_mem_rdata = 32'h1234_5678;
    @(negedge clock);
    n_checks++;
    if (obs_mem !== {1'b1, 1'b1, 32'h8000_1000, 2'd2, 1'b1, 32'hDEAD_BEEF, 4'hF} ||
        obs_resp !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678})
      $display("FAIL prio_lsu_first: got mem %h resp %h", obs_mem, obs_resp);
    else n_pass++;
    tick();
    d_lsu_req = 1'b0; d_mem_resp = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs_mem[72] !== 1'b0) $display("FAIL prio_bubble: got busy %b required 0", obs_mem[72]);
    else n_pass++;
    tick();
    d_mem_resp = 1'b1; d_mem_rdata = 32'h0000_0013;
    @(negedge clock);
    n_checks++;
    if (obs_mem !== {1'b1, 1'b1, 32'h8000_0040, 2'd2, 1'b0, 32'h0, 4'h0} ||
        obs_resp !== {1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b0, 32'h0})
      $display("FAIL prio_ifu_second: got mem %h resp %h", obs_mem, obs_resp);
    else n_pass++;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    sel = 1'b1;
    do_reset();
    d_ifu_req = 1'b1; d_ifu_addr = 32'h8000_0100;
    d_lsu_req = 1'b1; d_lsu_addr = 32'h8000_2000; d_lsu_size = 2'd2;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h8000_0100 : 32'h8000_2000;
      d_mem_resp = 1'b0;
      tick();
      d_mem_resp = 1'b1; d_mem_rdata = 32'(k);
      @(negedge clock);
      n_checks++;
      if (obs_mem[71] !== 1'b1 || obs_mem[70:39] !== exp_addr || obs_resp[67] !== (k % 2 == 0) || obs_resp[33] !== (k % 2 == 1))
        $display("FAIL rr_grant_%0d: got addr %h ifu_rv %b lsu_rv %b required addr %h", k, obs_mem[70:39], obs_resp[67], obs_resp[33], exp_addr);
      else n_pass++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    sel = 1'b0;
    do_reset();
    d_lsu_req = 1'b1; d_lsu_addr = 32'h8000_2003; d_lsu_size = 2'd0; d_lsu_wen = 1'b0;
    d_mem_rdata = 32'hA5A5_A5A5;
    tick();
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clock);
      n_checks++;
      if (c < TMO && (obs_resp !== 68'h0 || obs_mem[71] !== 1'b1))
        $display("FAIL timeout_wait_%0d: got resp %h reqValid %b", c, obs_resp, obs_mem[71]);
      else if (c == TMO && obs_resp !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0})
        $display("FAIL timeout_err: got resp %h required lsu err with rdata 0", obs_resp);
      else n_pass++;
      tick();
    end
    d_lsu_req = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs_mem[72] !== 1'b0) $display("FAIL timeout_idle: got busy %b required 0", obs_mem[72]);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    do_reset();
    d_lsu_req = 1'b1; d_lsu_addr = 32'h8000_3000; d_lsu_size = 2'd1; d_lsu_wen = 1'b1; d_lsu_wdata = 32'h0000_BEEF; d_lsu_wmask = 4'h3;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; d_lsu_req = 1'b0; d_mem_resp = 1'b1; d_mem_rdata = 32'h5555_AAAA;
    @(negedge clock);
    n_checks++;
    if (obs_mem !== 73'h0 || obs_resp !== 68'h0) $display("FAIL reset_mid: got mem %h resp %h required 0", obs_mem, obs_resp);
    else n_pass++;
    tick();
    d_mem_resp = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs_mem[72] !== 1'b0) $display("FAIL reset_mid_after: got busy %b required 0", obs_mem[72]);
    else n_pass++;
    tick();
  endtask

  task automatic test_spurious();
    sel = 1'b0;
    do_reset();
    d_mem_resp = 1'b1; d_mem_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    n_checks++;
    if (obs_resp !== 68'h0 || obs_mem !== 73'h0) $display("FAIL spurious: got resp %h mem %h required 0", obs_resp, obs_mem);
    else n_pass++;
    tick();
    d_mem_resp = 1'b0;
    @(negedge clock);
    n_checks++;
    if (obs_mem[72] !== 1'b0) $display("FAIL spurious_after: got busy %b required 0", obs_mem[72]);
    else n_pass++;
    tick();
  endtask

  // owner/last_grant: 0 none, 1 IFU, 2 LSU; delay = busy cycle index at which memory answers
  task automatic test_random(input logic rr, input int ncyc);
    logic        ifu_pend, lsu_pend, lsu_we, done, tmo;
    logic [31:0] ifu_a, lsu_a, lsu_wd, l_addr, l_wdata;
    logic [1:0]  lsu_sz, l_size;
    logic [3:0]  lsu_wm, l_wmask;
    logic        l_wen;
    logic [67:0] exp_resp;
    logic [72:0] exp_mem;
    int          owner, last_grant, cnt, delay, winner;
    sel = rr;
    do_reset();
    ifu_pend = 1'b0; lsu_pend = 1'b0; owner = 0; last_grant = 0; cnt = 0; delay = 0;
    ifu_a = 32'h0; lsu_a = 32'h0; lsu_wd = 32'h0; lsu_sz = 2'd0; lsu_we = 1'b0; lsu_wm = 4'h0;
    l_addr = 32'h0; l_wdata = 32'h0; l_size = 2'd0; l_wmask = 4'h0; l_wen = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (!ifu_pend && $urandom_range(0, 2) == 0) begin
        ifu_pend = 1'b1; ifu_a = $urandom;
      end
      if (!lsu_pend && $urandom_range(0, 2) == 0) begin
        lsu_pend = 1'b1; lsu_a = $urandom; lsu_sz = 2'($urandom_range(0, 2)); lsu_we = 1'($urandom);
        lsu_wd = $urandom; lsu_wm = 4'($urandom);
      end
      d_ifu_req  = ifu_pend;
      d_ifu_addr = (ifu_pend && owner != 1) ? ifu_a : $urandom;
      d_lsu_req  = lsu_pend;
      if (lsu_pend && owner != 2) begin
        d_lsu_addr = lsu_a; d_lsu_size = lsu_sz; d_lsu_wen = lsu_we; d_lsu_wdata = lsu_wd; d_lsu_wmask = lsu_wm;
      end else begin
        d_lsu_addr = $urandom; d_lsu_size = 2'($urandom); d_lsu_wen = 1'($urandom); d_lsu_wdata = $urandom; d_lsu_wmask = 4'($urandom);
      end
      d_mem_resp  = (owner != 0) ? (cnt == delay) : ($urandom_range(0, 7) == 0);
      d_mem_rdata = $urandom;
      @(negedge clock);
      done = 1'b0; tmo = 1'b0; exp_resp = 68'h0; exp_mem = 73'h0;
      if (owner != 0) begin
        if (d_mem_resp) done = 1'b1;
        else if (cnt == TMO - 1) begin done = 1'b1; tmo = 1'b1; end
        exp_mem = {1'b1, 1'b1, l_addr, l_size, l_wen, l_wdata, l_wmask};
        if (done && owner == 1) exp_resp[67:34] = {1'b1, tmo, tmo ? 32'h0 : d_mem_rdata};
        if (done && owner == 2) exp_resp[33:0]  = {1'b1, tmo, tmo ? 32'h0 : d_mem_rdata};
      end
      n_checks++;
      if (obs_resp !== exp_resp) $display("FAIL rand%0d_resp cyc %0d: got %h required %h", rr, cyc, obs_resp, exp_resp);
      else n_pass++;
      n_checks++;
      if (obs_mem !== exp_mem) $display("FAIL rand%0d_mem cyc %0d: got %h required %h", rr, cyc, obs_mem, exp_mem);
      else n_pass++;
      if (owner != 0) begin
        if (done) begin
          if (owner == 1) ifu_pend = 1'b0;
          else lsu_pend = 1'b0;
          owner = 0;
        end else begin
          cnt++;
        end
      end else if (ifu_pend || lsu_pend) begin
        if (ifu_pend && lsu_pend) winner = rr ? ((last_grant == 1) ? 2 : 1) : 2;
        else winner = ifu_pend ? 1 : 2;
        owner = winner; last_grant = winner; cnt = 0; delay = $urandom_range(0, 5);
        if (winner == 1) begin
          l_addr = ifu_a; l_size = 2'd2; l_wen = 1'b0; l_wdata = 32'h0; l_wmask = 4'h0;
        end else begin
          l_addr = lsu_a; l_size = lsu_sz; l_wen = lsu_we; l_wdata = lsu_wd; l_wmask = lsu_wm;
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    sel      = 1'b0;
    reset    = 1'b0;
    idle_inputs();
    test_reset();
    test_ifu_single();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random(1'b0, 600);
    test_random(1'b1, 600);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
